demux1x4_buf: RTL and testbench
===============================

Name: demux1x4_buf

Overview:
- Registered 1-to-4 demultiplexer with valid/ready handshakes.
- It is the distribution-side counterpart to the datapath select muxes: it steers one producer stream to one of four consumers, chosen by a 2-bit select.
- Each output has a 2-entry FIFO, so a stalled consumer blocks only its own channel.
- Used between the issue/result stage and per-unit consumers such as ALU, load/store, branch and writeback.

Parameters:
- DATA_WIDTH, 3, width of the data word carried through every channel.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  DATA_WIDTH  producer data word.
- in_sel  input  2  destination channel 0..3; meaningful only when in_valid=1.
- in_valid  input  1  producer offers in_data/in_sel this cycle.
- in_ready  output  1  the selected channel can accept this cycle.
- out0_data, out1_data, out2_data, out3_data  output  DATA_WIDTH each  head (oldest) entry of that channel's FIFO.
- out_valid  output  4  bit k=1 means channel k FIFO is non-empty.
- out_ready  input  4  bit k=1 means consumer k takes its head this cycle.
- busy  output  1  OR of out_valid.

Behaviour:
- Reset (async, active-high):
  - All FIFOs empty; out_valid=0, busy=0.
  - All outN_data=0.
  - Occupancy counters=0.
  - Takes effect immediately, including mid-transfer. In-flight data is discarded and nothing is accepted while reset=1.
- Channel k storage:
  - Two registers, slot0 (head) and slot1, plus a 2-bit occupancy count cnt_k in the range 0..2.
  - outk_data = slot0 at all times.
- in_ready:
  - Combinational: in_ready = (cnt[in_sel] != 2), independent of in_valid.
  - No same-cycle pass-through: a full channel deasserts in_ready even if its consumer pops in that same cycle.
- Push on channel k = in_valid & in_ready & (in_sel==k).
- Pop on channel k = out_valid[k] & out_ready[k]. out_ready on an empty channel is ignored.
- Per-channel update on the clock edge:
  - Push only, cnt=0: slot0<=in_data; cnt=1.
  - Push only, cnt=1: slot1<=in_data; cnt=2.
  - Pop only, cnt=2: slot0<=slot1; cnt=1.
  - Pop only, cnt=1: cnt=0; slot0 retains its old value (data is don't-care while invalid).
  - Push+pop, cnt=1: slot0<=in_data; cnt stays 1.
  - Push+pop, cnt=2: impossible, because in_ready=0.
  - Neither: hold.
- Outputs:
  - out_valid[k] = (cnt_k != 0), registered state.
  - busy = |out_valid.
- Latency:
  - Accept at edge N gives out_valid at edge N+1 (one cycle).
  - Maximum throughput is one transfer per cycle into any non-full channel.
- Ordering:
  - Strict FIFO order within a channel.
  - No ordering relation between channels.
- Independence: a push to channel j never alters the state of channel k (k != j).
- Producer rule: once in_valid=1 with a given in_sel, the producer holds in_data/in_sel until accepted. The bench checks this rule; the block does not enforce it.
- No X propagation: all state registers are reset.

Test Plan:
- Reset then idle:
  - Assert reset mid-cycle.
  - Expect: out_valid=4'b0000, busy=0, in_ready=1 for every in_sel, all outN_data=0, with no clock edge required.
- Single routing, DATA_WIDTH=3:
  - Push 3'd5 with in_sel=2 and out_ready=4'b0000.
  - Expect: next cycle out_valid=4'b0100 and out2_data=5.
  - Then raise out_ready[2]. Expect: out_valid=0 one cycle later.
- Fill and backpressure:
  - With out_ready=0, push 1 then 6 to channel 1.
  - Expect: out_valid[1]=1, in_ready=0 while in_sel=1, in_ready=1 while in_sel=0.
  - Pop twice. Expect: out1_data reads 1 then 6.
- Simultaneous push and pop:
  - Channel 3 holds 4 (cnt=1). Push 7 with in_sel=3 while out_ready[3]=1.
  - Expect: next cycle out3_data=7, out_valid[3]=1, cnt stays 1.
- Full channel, same-cycle pop:
  - Channel 0 is full. Set out_ready[0]=1 and offer in_sel=0.
  - Expect: in_ready=0 that cycle.
  - Expect: next cycle in_ready=1 and out0_data equals the former slot1.
- Reset mid-operation:
  - With channels 0 and 2 full, pulse reset between edges.
  - Expect: out_valid=0 immediately, and the first post-reset push appears alone (no stale data).

Source files
------------

// File: rtl/demux1x4_buf.sv
// ---------------------------------------------------------------------------
// demux1x4_buf
//
// Registered 1-to-4 demultiplexer with valid/ready handshakes. A single
// producer stream is steered to one of four consumers by a 2-bit select.
// Each consumer channel has its own 2-entry FIFO. A stalled consumer therefore
// only blocks traffic that is headed for its own channel.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_data    producer data word
//   in_sel     destination channel 0..3 (meaningful when in_valid=1)
//   in_valid   producer offers in_data/in_sel this cycle
//   in_ready   selected channel can accept this cycle (combinational)
//   outN_data  head (oldest) entry of channel N's FIFO
//   out_valid  bit k set when channel k's FIFO is non-empty
//   out_ready  bit k set when consumer k takes its head this cycle
//   busy       OR of out_valid
// ---------------------------------------------------------------------------
module demux1x4_buf #(
    parameter int DATA_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out0_data,
    output logic [DATA_WIDTH-1:0] out1_data,
    output logic [DATA_WIDTH-1:0] out2_data,
    output logic [DATA_WIDTH-1:0] out3_data,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic                  busy
);

    // Per-channel storage: slot0 is the head, slot1 is the second entry.
    logic [DATA_WIDTH-1:0] r_slot0 [4];
    logic [DATA_WIDTH-1:0] r_slot1 [4];
    logic [1:0]            r_cnt   [4];

    logic [3:0] w_push;
    logic [3:0] w_pop;

    // The ready signal depends on fullness only. It deliberately ignores a
    // pop that happens in the same cycle, so there is no combinational path
    // from out_ready to in_ready.
    assign in_ready = (r_cnt[in_sel] != 2'd2);

    genvar gk;
    generate
        for (gk = 0; gk < 4; gk++) begin : g_chan
            assign w_push[gk]    = in_valid & in_ready & (in_sel == 2'(gk));
            assign w_pop[gk]     = out_valid[gk] & out_ready[gk];
            assign out_valid[gk] = (r_cnt[gk] != 2'd0);

            // Two-entry FIFO update. A simultaneous push and pop can only
            // occur at occupancy 1. Occupancy 0 has nothing to pop, and
            // occupancy 2 has in_ready low. In that case the new word
            // simply replaces the head.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_slot0[gk] <= '0;
                    r_slot1[gk] <= '0;
                    r_cnt[gk]   <= 2'd0;
                end else begin
                    case ({w_push[gk], w_pop[gk]})
                        2'b10: begin
                            if (r_cnt[gk] == 2'd0) begin
                                r_slot0[gk] <= in_data;
                                r_cnt[gk]   <= 2'd1;
                            end else begin
                                r_slot1[gk] <= in_data;
                                r_cnt[gk]   <= 2'd2;
                            end
                        end
                        2'b01: begin
                            if (r_cnt[gk] == 2'd2) begin
                                r_slot0[gk] <= r_slot1[gk];
                                r_cnt[gk]   <= 2'd1;
                            end else begin
                                r_cnt[gk]   <= 2'd0;
                            end
                        end
                        2'b11: begin
                            r_slot0[gk] <= in_data;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    endgenerate

    assign out0_data = r_slot0[0];
    assign out1_data = r_slot0[1];
    assign out2_data = r_slot0[2];
    assign out3_data = r_slot0[3];
    assign busy      = |out_valid;

endmodule

// File: tb/tb_demux1x4_buf.sv
// ---------------------------------------------------------------------------
// tb_demux1x4_buf
//
// Self-checking bench for demux1x4_buf. It uses a table of directed vectors.
// Each vector carries the inputs for one cycle, the expected in_ready before
// the edge, and the expected valid/data state after the edge. Hand-written
// sequences cover the reset behaviour.
// ---------------------------------------------------------------------------
module tb_demux1x4_buf;

    localparam int DW = 3;
    localparam int NV = 20;

    logic          clk;
    logic          reset;
    logic [DW-1:0] in_data;
    logic [1:0]    in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out0_data, out1_data, out2_data, out3_data;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic          busy;

    int tests;
    int fails;

    // Producer-hold tracking: records an offer that was refused.
    logic          pendHold;
    logic [DW-1:0] pendData;
    logic [1:0]    pendSel;

    // The expected data is packed as {d3,d2,d1,d0}.
    // It is compared only for channels that are expected to be valid.
    typedef struct {
        logic [DW-1:0]   din;
        logic [1:0]      sel;
        logic            vld;
        logic [3:0]      ordy;
        logic            expRdy;
        logic [3:0]      expValid;
        logic [4*DW-1:0] expData;
    } vec_t;

    vec_t vecs [NV];

    demux1x4_buf #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out0_data (out0_data),
        .out1_data (out1_data),
        .out2_data (out2_data),
        .out3_data (out3_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] chanData(input int k);
        case (k)
            0:       chanData = out0_data;
            1:       chanData = out1_data;
            2:       chanData = out2_data;
            default: chanData = out3_data;
        endcase
    endfunction

    // Checks valid and busy, plus the head data of every channel expected valid.
    task automatic checkState(input string tag, input logic [3:0] expValid, input logic [4*DW-1:0] expData);
        checkOutput({tag, " out_valid"}, 8'(out_valid), 8'(expValid));
        checkOutput({tag, " busy"}, 8'(busy), 8'(|expValid));
        for (int k = 0; k < 4; k++) begin
            if (expValid[k]) begin
                checkOutput($sformatf("%s out%0d_data", tag, k), 8'(chanData(k)), 8'(expData[k*DW +: DW]));
            end
        end
    endtask

    // One cycle: drive at negedge, check in_ready, clock, then check the
    // registered state just after the edge.
    task automatic applyStimulus(input string tag, input vec_t v);
        @(negedge clk);
        if (pendHold) begin
            checkOutput({tag, " producer hold"}, {5'd0, v.vld, v.sel}, {5'd0, 1'b1, pendSel});
            checkOutput({tag, " producer data"}, 8'(v.din), 8'(pendData));
        end
        in_data   = v.din;
        in_sel    = v.sel;
        in_valid  = v.vld;
        out_ready = v.ordy;
        #1;
        checkOutput({tag, " in_ready"}, 8'(in_ready), 8'(v.expRdy));
        pendHold = v.vld & ~in_ready;
        pendData = v.din;
        pendSel  = v.sel;
        @(posedge clk);
        #1;
        checkState(tag, v.expValid, v.expData);
    endtask

    function automatic vec_t mk(input logic [DW-1:0] din, input logic [1:0] sel, input logic vld,
                                input logic [3:0] ordy, input logic rdy, input logic [3:0] ev,
                                input logic [DW-1:0] d3, input logic [DW-1:0] d2,
                                input logic [DW-1:0] d1, input logic [DW-1:0] d0);
        vec_t v;
        v.din = din; v.sel = sel; v.vld = vld; v.ordy = ordy;
        v.expRdy = rdy; v.expValid = ev; v.expData = {d3, d2, d1, d0};
        return v;
    endfunction

    initial begin
        tests    = 0;
        fails    = 0;
        pendHold = 1'b0;
        pendData = '0;
        pendSel  = '0;
        reset     = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        in_valid  = 1'b0;
        out_ready = 4'b0000;

        // Single routing followed by a pop.
        vecs[0]  = mk(3'd5, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0100, 0, 5, 0, 0);
        vecs[1]  = mk(3'd0, 2'd2, 1'b0, 4'b0100, 1'b1, 4'b0000, 0, 0, 0, 0);
        // Fill channel 1, observe backpressure, then drain it in order.
        vecs[2]  = mk(3'd1, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0010, 0, 0, 1, 0);
        vecs[3]  = mk(3'd6, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0010, 0, 0, 1, 0);
        vecs[4]  = mk(3'd0, 2'd1, 1'b0, 4'b0000, 1'b0, 4'b0010, 0, 0, 1, 0);
        vecs[5]  = mk(3'd0, 2'd0, 1'b0, 4'b0000, 1'b1, 4'b0010, 0, 0, 1, 0);
        vecs[6]  = mk(3'd0, 2'd1, 1'b0, 4'b0010, 1'b0, 4'b0010, 0, 0, 6, 0);
        vecs[7]  = mk(3'd0, 2'd1, 1'b0, 4'b0010, 1'b1, 4'b0000, 0, 0, 0, 0);
        // Simultaneous push and pop on channel 3 at occupancy 1.
        vecs[8]  = mk(3'd4, 2'd3, 1'b1, 4'b0000, 1'b1, 4'b1000, 4, 0, 0, 0);
        vecs[9]  = mk(3'd7, 2'd3, 1'b1, 4'b1000, 1'b1, 4'b1000, 7, 0, 0, 0);
        vecs[10] = mk(3'd0, 2'd3, 1'b0, 4'b0000, 1'b1, 4'b1000, 7, 0, 0, 0);
        vecs[11] = mk(3'd0, 2'd3, 1'b0, 4'b1000, 1'b1, 4'b0000, 0, 0, 0, 0);
        // Full channel 0: a same-cycle pop does not open in_ready.
        vecs[12] = mk(3'd2, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0001, 0, 0, 0, 2);
        vecs[13] = mk(3'd3, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0001, 0, 0, 0, 2);
        vecs[14] = mk(3'd1, 2'd0, 1'b1, 4'b0001, 1'b0, 4'b0001, 0, 0, 0, 3);
        vecs[15] = mk(3'd1, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0001, 0, 0, 0, 3);
        // Push to one channel while another pops. The channels stay independent.
        vecs[16] = mk(3'd4, 2'd1, 1'b1, 4'b0001, 1'b1, 4'b0011, 0, 0, 4, 1);
        vecs[17] = mk(3'd5, 2'd2, 1'b1, 4'b0011, 1'b1, 4'b0100, 0, 5, 0, 0);
        vecs[18] = mk(3'd0, 2'd2, 1'b0, 4'b0100, 1'b1, 4'b0000, 0, 0, 0, 0);
        // out_ready on empty channels is ignored.
        vecs[19] = mk(3'd0, 2'd0, 1'b0, 4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0);

        // Reset asserted mid-cycle takes effect without any clock edge.
        #2;
        reset = 1'b1;
        #1;
        checkState("reset", 4'b0000, '0);
        checkOutput("reset out0_data", 8'(out0_data), 8'd0);
        checkOutput("reset out1_data", 8'(out1_data), 8'd0);
        checkOutput("reset out2_data", 8'(out2_data), 8'd0);
        checkOutput("reset out3_data", 8'(out3_data), 8'd0);
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            checkOutput($sformatf("reset in_ready sel%0d", s), 8'(in_ready), 8'd1);
        end
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset mid-operation: fill channels 0 and 2, then pulse reset between edges.
        applyStimulus("mr fill0a", mk(3'd1, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0001, 0, 0, 0, 1));
        applyStimulus("mr fill0b", mk(3'd2, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0001, 0, 0, 0, 1));
        applyStimulus("mr fill2a", mk(3'd3, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0101, 0, 3, 0, 1));
        applyStimulus("mr fill2b", mk(3'd4, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0101, 0, 3, 0, 1));
        @(negedge clk);
        in_valid = 1'b0;
        in_sel   = 2'd0;
        #1;
        checkOutput("mr full in_ready", 8'(in_ready), 8'd0);
        #1;
        reset = 1'b1;
        #1;
        checkState("mr reset", 4'b0000, '0);
        checkOutput("mr reset out0_data", 8'(out0_data), 8'd0);
        checkOutput("mr reset out2_data", 8'(out2_data), 8'd0);
        checkOutput("mr reset in_ready", 8'(in_ready), 8'd1);
        #1;
        reset = 1'b0;
        applyStimulus("mr post push", mk(3'd6, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0001, 0, 0, 0, 6));
        applyStimulus("mr post pop",  mk(3'd0, 2'd0, 1'b0, 4'b0001, 1'b1, 4'b0000, 0, 0, 0, 0));
        applyStimulus("mr post idle", mk(3'd0, 2'd2, 1'b0, 4'b0000, 1'b1, 4'b0000, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
